// File: rtl/button_color_select.sv
// Debounced pushbutton to colour-index stepper; optional hold-to-repeat via BUTTON_COLOR_SELECT_AUTO_REPEAT_EN.
// Press/release accepted DEBOUNCE_CYCLES+2 cycles after the input settles; no backpressure, step is a 1-cycle pulse.
module button_color_select #(
   parameter int DEBOUNCE_CYCLES = 120000,
   parameter int HOLD_CYCLES     = 6000000,
   parameter int REPEAT_CYCLES   = 2000000,
   parameter int NUM_COLORS      = 6
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       btn_n,
   output logic [2:0] color_state,
   output logic       step,
   output logic       pressed
);

   localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
   localparam logic [2:0] COLOR_LAST = 3'(NUM_COLORS - 1);

`ifdef BUTTON_COLOR_SELECT_AUTO_REPEAT_EN
   localparam int TMR_MAX = (HOLD_CYCLES > REPEAT_CYCLES) ? HOLD_CYCLES : REPEAT_CYCLES;
   localparam int TMR_W   = (TMR_MAX > 1) ? $clog2(TMR_MAX) : 1;
   localparam logic [TMR_W-1:0] HOLD_LAST   = TMR_W'(HOLD_CYCLES - 1);
   localparam logic [TMR_W-1:0] REPEAT_LAST = TMR_W'(REPEAT_CYCLES - 1);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_HOLD   = 2'd1,
      S_REPEAT = 2'd2
   } state_e;

   logic [TMR_W-1:0] tmr_q, tmr_d;
`else
   typedef enum logic {
      S_IDLE = 1'b0,
      S_HELD = 1'b1
   } state_e;

   logic unused_cfg;
   assign unused_cfg = (HOLD_CYCLES > 0) ^ (REPEAT_CYCLES > 0);
`endif

   state_e           state_q, state_d;
   logic             sync1_q, sync1_d;
   logic             sync2_q, sync2_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pressed_q, pressed_d;
   logic [2:0]       color_q, color_d;
   logic             step_q, step_d;

   logic             btn_s;
   logic             accept;
   logic             press_evt;
   logic             release_evt;
   logic [2:0]       color_next;

   assign btn_s       = sync2_q;
   // accept marks the edge on which the debounced level flips
   assign accept      = (btn_s != pressed_q) && (cnt_q == CNT_LAST);
   assign press_evt   = accept && btn_s;
   assign release_evt = accept && !btn_s;
   assign color_next  = (color_q == COLOR_LAST) ? 3'd0 : color_q + 3'd1;

   always_comb begin
      sync1_d   = ~btn_n;
      sync2_d   = sync1_q;
      cnt_d     = cnt_q;
      pressed_d = pressed_q;
      if (btn_s == pressed_q) begin
         cnt_d = '0;
      end else if (cnt_q == CNT_LAST) begin
         pressed_d = btn_s;
         cnt_d     = '0;
      end else begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      color_d = color_q;
      step_d  = 1'b0;
`ifdef BUTTON_COLOR_SELECT_AUTO_REPEAT_EN
      tmr_d   = tmr_q;
      case (state_q)
         S_IDLE: begin
            tmr_d = '0;
            if (press_evt) begin
               step_d  = 1'b1;
               color_d = color_next;
               state_d = S_HOLD;
            end
         end
         // release is tested before expiry so a coincident release suppresses the step
         S_HOLD: begin
            if (release_evt) begin
               state_d = S_IDLE;
               tmr_d   = '0;
            end else if (tmr_q == HOLD_LAST) begin
               step_d  = 1'b1;
               color_d = color_next;
               state_d = S_REPEAT;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         S_REPEAT: begin
            if (release_evt) begin
               state_d = S_IDLE;
               tmr_d   = '0;
            end else if (tmr_q == REPEAT_LAST) begin
               step_d  = 1'b1;
               color_d = color_next;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q + 1'b1;
            end
         end
         default: begin
            state_d = S_IDLE;
            tmr_d   = '0;
         end
      endcase
`else
      case (state_q)
         S_IDLE: begin
            if (press_evt) begin
               step_d  = 1'b1;
               color_d = color_next;
               state_d = S_HELD;
            end
         end
         S_HELD: begin
            if (release_evt) begin
               state_d = S_IDLE;
            end
         end
         default: state_d = S_IDLE;
      endcase
`endif
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_IDLE;
         sync1_q   <= 1'b0;
         sync2_q   <= 1'b0;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         color_q   <= 3'd0;
         step_q    <= 1'b0;
`ifdef BUTTON_COLOR_SELECT_AUTO_REPEAT_EN
         tmr_q     <= '0;
`endif
      end else begin
         state_q   <= state_d;
         sync1_q   <= sync1_d;
         sync2_q   <= sync2_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         color_q   <= color_d;
         step_q    <= step_d;
`ifdef BUTTON_COLOR_SELECT_AUTO_REPEAT_EN
         tmr_q     <= tmr_d;
`endif
      end
   end

   assign color_state = color_q;
   assign step        = step_q;
   assign pressed     = pressed_q;

endmodule

// File: tb/tb_button_color_select.sv
// Bench for button_color_select: directed and random button waveforms against a cycle-level reference model.
module tb_button_color_select;

   localparam int D  = 4;
   localparam int H  = 20;
   localparam int R  = 8;
   localparam int NC = 6;

   logic       clk   = 1'b0;
   logic       rst   = 1'b1;
   logic       btn_n = 1'b0;
   logic [2:0] color_state;
   logic       step;
   logic       pressed;

   int errors = 0;
   int checks = 0;
   int cyc    = 0;

   // Expected step cycles, pushed by the model and consumed by the monitor.
   int exp_q[$];

   // Reference model: raw samples reach the debouncer two edges late; a level is
   // accepted after D consecutive samples disagreeing with the current one.
   bit         raw_q[$];
   bit         m_pressed = 1'b0;
   bit         m_held    = 1'b0;
   int         m_run     = 0;
   logic [2:0] m_color   = 3'd0;
`ifdef BUTTON_COLOR_SELECT_AUTO_REPEAT_EN
   int         m_next    = 0;
`endif

   button_color_select #(
      .DEBOUNCE_CYCLES(D),
      .HOLD_CYCLES    (H),
      .REPEAT_CYCLES  (R),
      .NUM_COLORS     (NC)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .btn_n      (btn_n),
      .color_state(color_state),
      .step       (step),
      .pressed    (pressed)
   );

   always #5 clk = ~clk;

   function automatic void model_step();
      m_color = 3'((int'(m_color) + 1) % NC);
      exp_q.push_back(cyc);
   endfunction

   always @(posedge clk) begin : model
      bit bs;
      bit rise;
      bit fall;
      cyc++;
      if (rst) begin
         m_pressed = 1'b0;
         m_held    = 1'b0;
         m_run     = 0;
         m_color   = 3'd0;
         raw_q     = {};
         raw_q.push_back(1'b0);
         raw_q.push_back(1'b0);
      end else begin
         bs = raw_q.pop_front();
         raw_q.push_back(!btn_n);
         rise = 1'b0;
         fall = 1'b0;
         if (bs != m_pressed) begin
            m_run++;
            if (m_run == D) begin
               m_run     = 0;
               m_pressed = bs;
               rise      = bs;
               fall      = !bs;
            end
         end else begin
            m_run = 0;
         end
         if (!m_held) begin
            if (rise) begin
               m_held = 1'b1;
`ifdef BUTTON_COLOR_SELECT_AUTO_REPEAT_EN
               m_next = cyc + H;
`endif
               model_step();
            end
         end else if (fall) begin
            m_held = 1'b0;
         end
`ifdef BUTTON_COLOR_SELECT_AUTO_REPEAT_EN
         else if (cyc == m_next) begin
            m_next = cyc + R;
            model_step();
         end
`endif
      end
   end

   always @(negedge clk) begin : monitor
      bit exp_now;
      exp_now = (exp_q.size() > 0) && (exp_q[0] == cyc);
      checks++;
      if (step !== exp_now) begin
         errors++;
         $display("FAIL step cyc=%0d got=%b want=%b", cyc, step, exp_now);
      end
      if (exp_now) void'(exp_q.pop_front());
      checks++;
      if (pressed !== m_pressed || color_state !== m_color) begin
         errors++;
         $display("FAIL level cyc=%0d pressed got=%b want=%b color got=%0d want=%0d",
                  cyc, pressed, m_pressed, color_state, m_color);
      end
   end

   task automatic drive(input logic v, input int n);
      repeat (n) begin
         @(negedge clk);
         btn_n = v;
      end
   endtask

   task automatic apply_reset(input int n);
      @(negedge clk);
      rst = 1'b1;
      repeat (n) @(negedge clk);
      rst = 1'b0;
   endtask

   initial begin
      logic lvl;
      int   len;
      // Reset for 3 edges with the button already held.
      repeat (3) @(negedge clk);
      rst = 1'b0;
      drive(1'b0, 10);
      drive(1'b1, 20);
      // Clean press.
      drive(1'b0, 10);
      drive(1'b1, 15);
      // Bounce then settle low.
      repeat (4) begin
         drive(1'b0, 3);
         drive(1'b1, 1);
      end
      drive(1'b0, 12);
      drive(1'b1, 15);
      // Wrap through all colours from reset.
      apply_reset(2);
      repeat (6) begin
         drive(1'b0, 8);
         drive(1'b1, 10);
      end
      // Long hold for auto-repeat.
      drive(1'b0, 65);
      drive(1'b1, 15);
      // Release landing just before, exactly on, and just after the hold expiry.
      drive(1'b0, 19);
      drive(1'b1, 15);
      drive(1'b0, 20);
      drive(1'b1, 15);
      drive(1'b0, 21);
      drive(1'b1, 15);
      // Reset while held, then keep holding.
      drive(1'b0, 30);
      apply_reset(3);
      drive(1'b0, 40);
      drive(1'b1, 15);
      // Random bouncing with occasional long holds.
      repeat (250) begin
         lvl = 1'($urandom_range(0, 1));
         if ($urandom_range(0, 4) == 0) len = int'($urandom_range(20, 70));
         else len = int'($urandom_range(1, 6));
         drive(lvl, len);
      end
      drive(1'b1, 20);
      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL pending_steps got=%0d want=0", exp_q.size());
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
